spmv_fp16_mul: RTL and testbench

Two-stage pipelined FP16 multiplier that forms the matrix-element × vector-element product for the SpMV datapath. It sits directly upstream of the FP16 accumulate adder and drives its `mul_result` operand. A valid/ready handshake lets the accumulator stall the stream. The number format and special-case rules match the adder: biased exponent 0 is treated as zero, no subnormals, and results are truncated.

---
 rtl/spmv_fp16_mul.sv | 121 ++++++++++++
 tb/tb_spmv_fp16_mul.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spmv_fp16_mul.sv
// Two-stage pipelined FP16 multiplier feeding the SpMV accumulate adder.
// Exponent 0 reads as zero, no subnormals, truncation, saturation on overflow.
module spmv_fp16_mul #(
  parameter int unsigned FP16  = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [FP16-1:0]  i_a,
  input  logic [FP16-1:0]  i_b,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             o_ready,
  output logic [FP16-1:0]  o_mul_result,
  output logic             o_valid,
  output logic             o_last,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_prod_cnt
);

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  logic [6:0]  s1_esum_q, s1_esum_d;
  logic [21:0] s1_prod_q, s1_prod_d;
  logic        s1_zero_q, s1_zero_d;
  logic        s1_last_q, s1_last_d;

  // Stage 2 state
  logic        s2_valid_q, s2_valid_d;
  logic [15:0] s2_res_q, s2_res_d;
  logic        s2_last_q, s2_last_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              adv;
  logic signed [7:0] exp_s;
  logic [9:0]        man;
  logic [15:0]       res;
  // Truncated low product bits never reach the result.
  logic [9:0]        unused_prod_lo;

  assign unused_prod_lo = s1_prod_q[9:0];

  // The pipeline moves as a unit whenever the output slot is empty or drained.
  assign adv     = !s2_valid_q || i_ready;
  assign o_ready = adv;

  // Normalise, range-check and pack the stage-1 product.
  always_comb begin
    exp_s = $signed({1'b0, s1_esum_q}) - 8'sd15 + $signed({7'b0, s1_prod_q[21]});
    man   = s1_prod_q[21] ? s1_prod_q[20:11] : s1_prod_q[19:10];
    res   = {s1_sign_q, exp_s[4:0], man};
    if (s1_zero_q || exp_s <= 8'sd0) begin
      res = 16'h0000;
    end else if (exp_s >= 8'sd31) begin
      res = {s1_sign_q, 5'b11110, 10'h3FF};
    end
  end

  // Next-state for both stages and the handoff counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_esum_d  = s1_esum_q;
    s1_prod_d  = s1_prod_q;
    s1_zero_d  = s1_zero_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_last_d  = s2_last_q;
    cnt_d      = cnt_q;
    if (adv) begin
      s1_valid_d = i_valid;
      s1_sign_d  = i_a[15] ^ i_b[15];
      s1_esum_d  = {2'b00, i_a[14:10]} + {2'b00, i_b[14:10]};
      s1_prod_d  = {11'b0, 1'b1, i_a[9:0]} * {11'b0, 1'b1, i_b[9:0]};
      s1_zero_d  = (i_a[14:10] == 5'd0) || (i_b[14:10] == 5'd0);
      s1_last_d  = i_last;
      s2_valid_d = s1_valid_q;
      s2_res_d   = res;
      s2_last_d  = s1_last_q;
    end
    if (s2_valid_q && i_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_esum_q  <= '0;
      s1_prod_q  <= '0;
      s1_zero_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_last_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_esum_q  <= s1_esum_d;
      s1_prod_q  <= s1_prod_d;
      s1_zero_q  <= s1_zero_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_last_q  <= s2_last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_mul_result = s2_res_q;
  assign o_valid      = s2_valid_q;
  assign o_last       = s2_last_q;
  assign o_prod_cnt   = cnt_q;

endmodule

// File: tb/tb_spmv_fp16_mul.sv
// Directed bench for spmv_fp16_mul: hand-computed products, stream, stall, reset, counter wrap.
module tb_spmv_fp16_mul;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_last, i_ready;
  logic [15:0] i_a, i_b;
  logic        o_ready, o_valid, o_last;
  logic [15:0] o_mul_result;
  logic [15:0] o_prod_cnt;

  logic        w4_ready, w4_valid, w4_last;
  logic [15:0] w4_result;
  logic [3:0]  w4_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] res;
    logic        last;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  spmv_fp16_mul dut (
    .i_clk(clk), .i_rst(i_rst), .i_a(i_a), .i_b(i_b), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .o_mul_result(o_mul_result), .o_valid(o_valid), .o_last(o_last),
    .i_ready(i_ready), .o_prod_cnt(o_prod_cnt)
  );

  spmv_fp16_mul #(.CNT_W(4)) dut_w4 (
    .i_clk(clk), .i_rst(i_rst), .i_a(i_a), .i_b(i_b), .i_valid(i_valid), .i_last(i_last),
    .o_ready(w4_ready), .o_mul_result(w4_result), .o_valid(w4_valid), .o_last(w4_last),
    .i_ready(i_ready), .o_prod_cnt(w4_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Every output handshake must match the oldest accepted input's expected product.
  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'b0, o_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {16'b0, o_mul_result}, {16'b0, mon_e.res});
        check("last", {31'b0, o_last}, {31'b0, mon_e.last});
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                      input logic [15:0] res);
    bit   done = 1'b0;
    exp_t e;
    i_a = a; i_b = b; i_last = last; i_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (o_ready) begin
        e.res  = res;
        e.last = last;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept", {31'b0, o_ready}, 32'd1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_last  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (exp_q.size() == 0 && !o_valid) break;
      @(posedge clk); #1;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic pulse_reset();
    i_valid = 1'b0;
    i_rst   = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    i_rst = 1'b0;
  endtask

  initial begin
    bit seen;
    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    i_a = '0; i_b = '0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_result", {16'b0, o_mul_result}, 32'd0);
    check("rst_last", {31'b0, o_last}, 32'd0);
    check("rst_cnt", {16'b0, o_prod_cnt}, 32'd0);
    check("rst_ready", {31'b0, o_ready}, 32'd1);
    @(posedge clk); #1;

    // Latency: accepted on edge T0, visible after T1.
    send(16'h3C00, 16'h3C00, 1'b0, 16'h3C00);
    i_valid = 1'b0;
    @(negedge clk);
    check("lat_c1", {31'b0, o_valid}, 32'd0);
    @(negedge clk);
    check("lat_c2", {31'b0, o_valid}, 32'd1);
    @(posedge clk); #1;

    send(16'h3E00, 16'h3E00, 1'b0, 16'h4080);
    send(16'hC000, 16'h4200, 1'b0, 16'hC600);
    send(16'h7800, 16'h4000, 1'b0, 16'h7BFF);
    send(16'hF800, 16'h4000, 1'b0, 16'hFBFF);
    send(16'h0000, 16'h4500, 1'b0, 16'h0000);
    send(16'h0400, 16'h0400, 1'b0, 16'h0000);
    send(16'h8000, 16'h3C00, 1'b0, 16'h0000);
    send(16'h3C01, 16'h3C01, 1'b0, 16'h3C02);
    send(16'h7C00, 16'h3C00, 1'b0, 16'h7BFF);
    drain();
    check("cnt_basic", {16'b0, o_prod_cnt}, 32'd10);
    check("cnt_basic_w4", {28'b0, w4_cnt}, 32'd10);

    // Back-to-back stream of 8 with last on the final pair.
    pulse_reset();
    send(16'h3C00, 16'h3C00, 1'b0, 16'h3C00);
    send(16'h4000, 16'h4000, 1'b0, 16'h4400);
    send(16'h4200, 16'h4000, 1'b0, 16'h4600);
    send(16'h3E00, 16'h3E00, 1'b0, 16'h4080);
    send(16'hC000, 16'h4200, 1'b0, 16'hC600);
    send(16'h3800, 16'h4000, 1'b0, 16'h3C00);
    send(16'h7800, 16'h4000, 1'b0, 16'h7BFF);
    send(16'h0000, 16'h4500, 1'b1, 16'h0000);
    drain();
    check("cnt_stream", {16'b0, o_prod_cnt}, 32'd8);

    // Stall for 4 cycles as soon as the first of 3 outputs is valid.
    fork
      begin
        send(16'h4400, 16'h4000, 1'b0, 16'h4800);
        send(16'h3C00, 16'hC000, 1'b0, 16'hC000);
        send(16'h4500, 16'h3C00, 1'b0, 16'h4500);
        i_valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(posedge clk); #1;
          if (o_valid) begin
            i_ready = 1'b0;
            seen    = 1'b1;
          end
        end
        if (!seen) check("stall_start", {31'b0, o_valid}, 32'd1);
        repeat (4) begin
          @(negedge clk);
          check("stall_ready", {31'b0, o_ready}, 32'd0);
          check("stall_valid", {31'b0, o_valid}, 32'd1);
          check("stall_res", {16'b0, o_mul_result}, 32'h4800);
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
      end
    join
    drain();
    check("cnt_stall", {16'b0, o_prod_cnt}, 32'd11);

    // Six more handshakes take the 4-bit counter past 16.
    repeat (6) send(16'h3C00, 16'h3C00, 1'b0, 16'h3C00);
    drain();
    check("cnt_17", {16'b0, o_prod_cnt}, 32'd17);
    check("cnt_wrap_w4", {28'b0, w4_cnt}, 32'd1);

    // Reset with two products in flight.
    send(16'h4000, 16'h4000, 1'b0, 16'h4400);
    send(16'h4000, 16'h4000, 1'b0, 16'h4400);
    pulse_reset();
    @(negedge clk);
    check("mid_rst_valid", {31'b0, o_valid}, 32'd0);
    check("mid_rst_result", {16'b0, o_mul_result}, 32'd0);
    check("mid_rst_cnt", {16'b0, o_prod_cnt}, 32'd0);
    check("mid_rst_ready", {31'b0, o_ready}, 32'd1);
    idle(5);
    check("mid_rst_stale", {31'b0, o_valid}, 32'd0);
    check("mid_rst_cnt_after", {16'b0, o_prod_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
